// File: rtl/rotr_fixed_stage.sv
// Fixed-amount circular right rotate by S bit positions; pure wiring, no logic.
// Used once per pipeline stage with S = 2**k.
module rotr_fixed_stage #(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = {a[S-1:0], a[N-1:S]};

endmodule

// File: rtl/circular_right_rotator_pipe.sv
// Variable-amount circular right rotator, one pipeline stage per amount bit,
// with valid/ready handshakes on both sides and a combinational ready chain.
module circular_right_rotator_pipe #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("circular_right_rotator_pipe: N=%0d must be a power of 2 and >= 2", N);
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    logic          valid_q, valid_d;
    logic [N-1:0]  data_q, data_d;
    logic [SW-1:0] amt_q, amt_d;
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_amt;
    logic [N-1:0]  rot_data;
    logic          next_ready;
    logic          ready;

    if (k == 0) begin : g_src
      assign in_valid = up_valid;
      assign in_data  = up_data;
      assign in_amt   = up_amt;
    end else begin : g_src
      assign in_valid = g_stage[k-1].valid_q;
      assign in_data  = g_stage[k-1].data_q;
      assign in_amt   = g_stage[k-1].amt_q;
    end

    if (k == SW - 1) begin : g_snk
      assign next_ready = down_ready;
    end else begin : g_snk
      assign next_ready = g_stage[k+1].ready;
    end

    rotr_fixed_stage #(.N(N), .S(2 ** k)) u_rot (
      .a (in_data),
      .y (rot_data)
    );

    // A full stage may refill on the same edge it hands its word downstream.
    assign ready = !valid_q || next_ready;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      amt_d   = amt_q;
      if (ready) begin
        valid_d = in_valid;
        data_d  = in_amt[k] ? rot_data : in_data;
        amt_d   = in_amt;
      end
    end

    // NOTE: sequential state uses non-blocking assignments only, and the data
    // registers are reset too so down_data reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        amt_q   <= amt_d;
      end
    end
  end

  assign up_ready   = g_stage[0].ready;
  assign down_valid = g_stage[SW-1].valid_q;
  assign down_data  = g_stage[SW-1].data_q;

  // The last stage's amount has no consumer; it is kept only for uniformity.
  logic unused_amt;
  assign unused_amt = ^g_stage[SW-1].amt_q;

endmodule

// File: tb/tb_circular_right_rotator_pipe.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random valid/ready traffic scored against a queue-based reference model.
module tb_circular_right_rotator_pipe;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_amt;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;

  circular_right_rotator_pipe #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amt     (up_amt),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rot_model(input logic [N-1:0] a, input int s);
    int unsigned w;
    w = a;
    w = (w >> s) | (w << (N - s));
    return w[N-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word must come out once, in order, rotated.
  logic [N-1:0] exp_q[$];
  int           n_out = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (up_valid && up_ready) exp_q.push_back(rot_model(up_data, int'(up_amt)));
      if (down_valid && down_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_unexpected_output", 32'(down_data), 32'hDEAD);
        else check("sb_data", 32'(down_data), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic [N-1:0]  data;
    logic [SW-1:0] amt;
    logic [N-1:0]  exp;
  } vec_t;

  vec_t         vecs[7];
  logic [N-1:0] words[8];
  int           lat;
  int           accepts;
  bit           fire;

  initial begin
    vecs[0] = '{8'hA3, 3'd3, 8'h74};
    vecs[1] = '{8'hA3, 3'd0, 8'hA3};
    vecs[2] = '{8'h01, 3'd7, 8'h02};
    vecs[3] = '{8'h80, 3'd1, 8'h40};
    vecs[4] = '{8'h0F, 3'd4, 8'hF0};
    vecs[5] = '{8'h81, 3'd1, 8'hC0};
    vecs[6] = '{8'h5A, 3'd2, 8'h96};

    rst_n      = 1'b0;
    up_valid   = 1'b1;
    up_data    = 8'hFF;
    up_amt     = 3'd5;
    down_ready = 1'b1;

    // Reset held with up_valid high: nothing enters, outputs stay idle.
    for (int c = 0; c < 4; c++) begin
      step();
      check("rst_down_valid", 32'(down_valid), 32'd0);
      check("rst_down_data",  32'(down_data),  32'h00);
      check("rst_up_ready",   32'(up_ready),   32'd1);
    end
    up_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Directed vectors, one word at a time, with latency measurement.
    foreach (vecs[i]) begin
      up_data  = vecs[i].data;
      up_amt   = vecs[i].amt;
      up_valid = 1'b1;
      check("vec_up_ready", 32'(up_ready), 32'd1);
      step();
      up_valid = 1'b0;
      lat = 1;
      while (!down_valid && lat < 10) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_data", i), 32'(down_data), 32'(vecs[i].exp));
      step();
      check("vec_drained", 32'(down_valid), 32'd0);
    end

    // Streaming: eight back-to-back words with amounts 0..7.
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      up_valid = 1'b1;
      up_data  = words[i];
      up_amt   = 3'(i);
      step();
      if (i >= 2) begin
        check("stream_valid", 32'(down_valid), 32'd1);
        check($sformatf("stream_word%0d", i - 2), 32'(down_data), 32'(rot_model(words[i-2], i - 2)));
      end
    end
    up_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      step();
      check("stream_valid", 32'(down_valid), 32'd1);
      check($sformatf("stream_word%0d", i), 32'(down_data), 32'(rot_model(words[i], i)));
    end
    step();
    check("stream_drained", 32'(down_valid), 32'd0);

    // Backpressure: pipeline fills to three words, then releases them in order.
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    down_ready = 1'b0;
    accepts    = 0;
    up_valid   = 1'b1;
    up_data    = words[0];
    up_amt     = 3'd1;
    for (int c = 0; c < 6; c++) begin
      fire = up_ready;
      step();
      if (fire) begin
        accepts++;
        up_data = words[accepts];
      end
    end
    check("bp_accepts", accepts, 3);
    check("bp_up_ready_low", 32'(up_ready), 32'd0);
    down_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("bp_valid", 32'(down_valid), 32'd1);
      check($sformatf("bp_word%0d", k), 32'(down_data), 32'(rot_model(words[k], 1)));
      step();
      if (k + 4 < 6) up_data = words[k + 4];
      else up_valid = 1'b0;
    end
    check("bp_drained", 32'(down_valid), 32'd0);

    // Random valid/ready traffic; valid is held until the word is accepted.
    up_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      fire = up_valid && up_ready;
      if (fire || !up_valid) begin
        up_valid = ($urandom_range(0, 3) != 0);
        up_data  = 8'($urandom);
        up_amt   = 3'($urandom);
      end
      down_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    fire = up_valid && up_ready;
    step();
    up_valid   = 1'b0;
    down_ready = 1'b1;
    lat = 0;
    while ((exp_q.size() != 0 || down_valid) && lat < 20) begin
      step();
      lat++;
    end
    check("rand_drain_queue_empty", exp_q.size(), 0);
    check("rand_outputs_seen", 32'(n_out > 5000), 32'd1);

    // Async reset between edges with words in flight.
    down_ready = 1'b1;
    up_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_data = 8'($urandom);
      up_amt  = 3'($urandom);
      step();
    end
    check("pre_reset_valid", 32'(down_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_down_valid", 32'(down_valid), 32'd0);
    check("async_rst_down_data",  32'(down_data),  32'h00);
    check("async_rst_up_ready",   32'(up_ready),   32'd1);
    up_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_reset_no_stale", 32'(down_valid), 32'd0);
    end
    up_valid = 1'b1;
    up_data  = 8'hA3;
    up_amt   = 3'd3;
    step();
    up_valid = 1'b0;
    lat = 1;
    while (!down_valid && lat < 10) begin
      step();
      lat++;
    end
    check("post_reset_latency", lat, 3);
    check("post_reset_data", 32'(down_data), 32'h74);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
